// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, taken branches, multi-cycle multiply and memory wait.
// Ports: clk, rst (sync, active-high); id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 describe the ID instruction;
// id_ex_mem_read/id_ex_rd/ex_is_mul/ex_branch_taken describe the EX instruction; mem_wait stalls everything.
// Outputs: pc_en/if_id_en/id_ex_en/ex_mem_en register enables, if_id_flush/id_ex_flush bubble inserts,
// mul_busy/mul_done multiply status. With HAZARD_PERF_EN defined, stall_cycles/flush_count perf counters exist.
module hazard_ctrl #(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rd,
  input  logic       ex_is_mul,
  input  logic       ex_branch_taken,
  input  logic       mem_wait,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mul_busy,
  output logic       mul_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);
  typedef enum logic {RUN, MUL} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic load_use;
  assign load_use = id_ex_mem_read && id_ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
    {if_id_flush, id_ex_flush, mul_busy, mul_done} = 4'b0000;
    state_n = state;
    cnt_n = cnt;
    if (rst) begin
    end else if (mem_wait) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      mul_busy = state == MUL;
    end else if (state == MUL) begin
      mul_busy = 1'b1;
      if (cnt == 4'd0) begin
        mul_done = 1'b1;
        state_n = RUN;
      end else begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
        cnt_n = cnt - 4'd1;
      end
    end else if (ex_is_mul) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      mul_busy = 1'b1;
      state_n = MUL;
      cnt_n = 4'(MUL_LATENCY - 2);
    end else if (ex_branch_taken) begin
      {if_id_flush, id_ex_flush} = 2'b11;
    end else if (load_use) begin
      {pc_en, if_id_en} = 2'b00;
      id_ex_flush = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
`ifdef HAZARD_PERF_EN
  // if_id_flush is raised only by a taken branch, so it marks branch flushes exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush) flush_count <= flush_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks of hazard_ctrl with a scoreboard queue.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst, mem_wait, ex_is_mul, ex_branch_taken, id_ex_mem_read, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mul_busy, mul_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  always #5 clk = ~clk;
  hazard_ctrl #(.MUL_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mul_busy(mul_busy), .mul_done(mul_done)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );
  typedef struct {
    string name;
    logic rst, mw, mul, br, mr;
    logic [4:0] rd, rs1, rs2;
    logic u1, u2;
    logic [7:0] exp;
  } vec_t;
  // expected output order: pc_en if_id_en id_ex_en ex_mem_en if_id_flush id_ex_flush mul_busy mul_done
  localparam logic [7:0] RUNO = 8'b1111_0000;
  localparam logic [7:0] HOLD = 8'b0000_0000;
  localparam logic [7:0] MWM  = 8'b0000_0010;
  localparam logic [7:0] MULS = 8'b0000_0010;
  localparam logic [7:0] MULD = 8'b1111_0011;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] LU   = 8'b0011_0100;
  int n_vec = 0, n_err = 0;
  logic [7:0] sb[$];
  string sb_name[$];
  vec_t tbl[$];
  function automatic vec_t v(string name, logic r, logic mw, logic mul, logic br, logic mr,
                             logic [4:0] rd, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic [7:0] exp);
    vec_t t;
    t.name = name; t.rst = r; t.mw = mw; t.mul = mul; t.br = br; t.mr = mr;
    t.rd = rd; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.exp = exp;
    return t;
  endfunction
  task automatic step(input vec_t t);
    logic [7:0] got, exp;
    string nm;
    rst = t.rst; mem_wait = t.mw; ex_is_mul = t.mul; ex_branch_taken = t.br;
    id_ex_mem_read = t.mr; id_ex_rd = t.rd; id_rs1 = t.rs1; id_uses_rs1 = t.u1;
    id_rs2 = t.rs2; id_uses_rs2 = t.u2;
    sb.push_back(t.exp);
    sb_name.push_back(t.name);
    @(negedge clk);
    got = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mul_busy, mul_done};
    exp = sb.pop_front();
    nm = sb_name.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input string name, input logic [7:0] exp);
    step(v(name, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, exp));
  endtask
  initial begin
    #1;
    tbl.push_back(v("reset_forced",   1, 1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd5, 1, RUNO));
    tbl.push_back(v("idle",           0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, RUNO));
    tbl.push_back(v("lu_rs2",         0, 0, 0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, LU));
    tbl.push_back(v("lu_rs2_after",   0, 0, 0, 0, 0, 5'd5, 5'd0, 0, 5'd5, 1, RUNO));
    tbl.push_back(v("lu_rd0",         0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, RUNO));
    tbl.push_back(v("lu_rs1",         0, 0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd3, 1, LU));
    tbl.push_back(v("lu_rs1_unused",  0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd3, 1, RUNO));
    tbl.push_back(v("lu_rs2_unused",  0, 0, 0, 0, 1, 5'd9, 5'd1, 1, 5'd9, 0, RUNO));
    tbl.push_back(v("no_load",        0, 0, 0, 0, 0, 5'd7, 5'd7, 1, 5'd7, 1, RUNO));
    tbl.push_back(v("branch_and_lu",  0, 0, 0, 1, 1, 5'd5, 5'd0, 0, 5'd5, 1, BR));
    tbl.push_back(v("mw_branch",      0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, HOLD));
    tbl.push_back(v("mw_lu",          0, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, HOLD));
    tbl.push_back(v("branch",         0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, BR));
    tbl.push_back(v("branch_over_lu_rs1", 0, 0, 0, 1, 1, 5'd31, 5'd31, 1, 5'd0, 0, BR));
    foreach (tbl[i]) step(tbl[i]);
    // multiply, with branch/load-use/ex_is_mul noise while in MUL
    step(v("mul_c1", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULS));
    step(v("mul_c2", 0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULS));
    step(v("mul_c3", 0, 0, 1, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0, MULS));
    step(v("mul_c4_done", 0, 0, 1, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0, MULD));
    idle("mul_back_run", RUNO);
    // mem_wait blocks multiply entry, then holds cnt at 1 for two cycles
    step(v("mw_mul_entry", 0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, HOLD));
    step(v("mwm_c1", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULS));
    step(v("mwm_c2", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULS));
    step(v("mwm_wait1", 0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MWM));
    step(v("mwm_wait2", 0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MWM));
    step(v("mwm_c3", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULS));
    step(v("mwm_done", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULD));
    idle("mwm_back_run", RUNO);
    // reset at cnt=1 abandons the multiply
    step(v("rm_c1", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULS));
    step(v("rm_c2", 0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MULS));
    step(v("rm_reset", 1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, RUNO));
    idle("rm_after1", RUNO);
`ifdef HAZARD_PERF_EN
    n_vec++;
    if (stall_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL rm_stall_cycles: got %0d expected 0", stall_cycles);
    end
`endif
    idle("rm_after2", RUNO);
    idle("rm_after3", RUNO);
    step(v("post_lu", 0, 0, 0, 0, 1, 5'd2, 5'd2, 1, 5'd0, 0, LU));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: MUL_LATENCY, 4, total EX-stage cycles of a multiply; legal range 2..16.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination of the instruction in EX.
- ex_is_mul  in  1  instruction in EX is a multi-cycle multiply.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_wait  in  1  data memory not ready this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register enables.
- if_id_flush, id_ex_flush  out  1 each  convert register contents to NOP on the next edge.
- mul_busy  out  1  multiply occupying EX.
- mul_done  out  1  final multiply cycle; result valid.
- stall_cycles, flush_count  out  32 each  perf counters; present only with HAZARD_PERF_EN.

Function
REQ-003 SHALL have states RUN and MUL plus a 4-bit down-counter cnt.
REQ-004 SHALL compute outputs combinationally from state, cnt and inputs, with priority mem_wait > multiply > branch > load-use.
REQ-005 SHALL, when mem_wait=1 in any state:
- drive all four enables 0 and both flushes 0;
- hold state and cnt;
- perform no state entry.
REQ-006 SHALL, in RUN with ex_is_mul=1 and mem_wait=0:
- drive all enables 0 and mul_busy=1;
- go to MUL with cnt=MUL_LATENCY-2.
REQ-007 SHALL, in MUL with cnt!=0 and mem_wait=0, drive all enables 0 and mul_busy=1, then decrement cnt.
REQ-008 SHALL, in MUL with cnt==0 and mem_wait=0:
- drive all enables 1, mul_busy=1 and mul_done=1;
- return to RUN.
- Result: EX occupancy is exactly MUL_LATENCY cycles, with MUL_LATENCY-1 stall cycles.
REQ-009 SHALL ignore ex_is_mul, ex_branch_taken and load-use while in MUL.
REQ-010 SHALL, in RUN with ex_branch_taken=1, no multiply and mem_wait=0, drive all enables 1 with if_id_flush=1 and id_ex_flush=1 for that cycle.
REQ-011 SHALL define load-use as: id_ex_mem_read AND id_ex_rd!=0 AND ((id_uses_rs1 AND id_rs1==id_ex_rd) OR (id_uses_rs2 AND id_rs2==id_ex_rd)).
REQ-012 SHALL, on load-use in RUN with no higher-priority event:
- drive pc_en=0, if_id_en=0, id_ex_en=1, ex_mem_en=1;
- drive id_ex_flush=1 (bubble) and if_id_flush=0;
- stall exactly one cycle, because the load advances.
REQ-013 SHALL, in RUN with no event, drive all enables 1, flushes 0, mul_busy 0, mul_done 0.
REQ-014 SHALL never assert if_id_flush or id_ex_flush in a cycle where the corresponding enable is 0.

Reset
REQ-015 SHALL, on a clk edge with rst=1, set state=RUN and cnt=0, and clear the perf counters.
REQ-016 SHALL, while rst=1 and regardless of other inputs, drive all enables 1, both flushes 0, mul_busy 0 and mul_done 0.
REQ-017 SHALL treat rst asserted mid-multiply as abandoning it: no mul_done is issued after reset.

Configuration
REQ-018 SHALL, with HAZARD_PERF_EN defined:
- provide stall_cycles, which increments on every cycle with pc_en=0 and rst=0;
- provide flush_count, which increments on every cycle with id_ex_flush=1 due to a branch;
- both counters wrap at 2^32.
REQ-019 SHALL, without HAZARD_PERF_EN, omit both ports and their logic entirely.

Verification
REQ-020 SHALL cover a load-use case:
- stimulus: id_ex_mem_read=1, id_ex_rd=5, id_rs2=5, id_uses_rs2=1;
- response: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then all enables 1;
- also repeat with id_ex_rd=0: no stall.
REQ-021 SHALL cover a multiply with MUL_LATENCY=4:
- stimulus: ex_is_mul=1 in RUN;
- response: 3 cycles with all enables 0, then mul_done=1 with enables 1 in the 4th cycle, then RUN.
REQ-022 SHALL cover mem_wait during a multiply:
- stimulus: mem_wait=1 for 2 cycles at cnt=1;
- response: cnt held, so mul_done is delayed exactly 2 cycles.
REQ-023 SHALL cover a branch coinciding with load-use:
- stimulus: ex_branch_taken=1 together with a load-use match;
- response: both flushes 1, pc_en=1, no stall.
REQ-024 SHALL cover reset mid-multiply:
- stimulus: rst=1 at cnt=1;
- response: next cycle RUN, enables 1, no mul_done; with HAZARD_PERF_EN, stall_cycles=0.
